// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared types for the pipelined carry-select adder/subtractor.
//   op_e : operation select carried on in_op (OP_ADD = 0, OP_SUB = 1)
// All widths come from module parameters, so no width constants live here.
// ---------------------------------------------------------------------------
package csa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/csa_block.sv
// ---------------------------------------------------------------------------
// csa_block
// Combinational BLOCK-bit carry-select slice. Both candidate sums (carry-in 0
// and carry-in 1) are formed up front and the real carry-in only drives the
// final select.
// Ports:
//   a, b  in  BLOCK  slice operands (b already inverted for subtraction)
//   cin   in  1      carry into the slice
//   sum   out BLOCK  slice sum
//   cout  out 1      carry out of the slice MSB
//   cmsb  out 1      carry into the slice MSB (used for signed overflow)
// ---------------------------------------------------------------------------
module csa_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK:0] res_c0;
  logic [BLOCK:0] res_c1;

  always_comb begin
    res_c0 = {1'b0, a} + {1'b0, b};
    res_c1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
    if (cin) begin
      sum  = res_c1[BLOCK-1:0];
      cout = res_c1[BLOCK];
    end else begin
      sum  = res_c0[BLOCK-1:0];
      cout = res_c0[BLOCK];
    end
    // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out.
    cmsb = sum[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// One BLOCK-bit slice is resolved per stage; STAGES = WIDTH/BLOCK registers
// hold the in-flight beats, and the last register is the output.
// A beat accepted in a cycle is presented on out_valid STAGES cycles later.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake
//   in_a, in_b             WIDTH-bit operands
//   in_cin                 carry in (ADD only)
//   in_op                  OP_ADD / OP_SUB
//   out_valid/out_ready    result handshake
//   out_sum                WIDTH-bit result (modulo 2^WIDTH)
//   out_carry              carry out of MSB (SUB: 1 = no borrow)
//   out_ovf                signed two's-complement overflow
// ---------------------------------------------------------------------------
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("csa_pipe_adder: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
  end

  // word_q holds resolved sum slices in its low part and the still-pending
  // slices of operand A in its high part; b_q holds the (inverted for SUB)
  // B operand; carry_q is the carry into the next slice to be resolved.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  b_d    [STAGES];
  logic              ovf_q, ovf_d;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_word [STAGES];
  logic [WIDTH-1:0]  src_b    [STAGES];
  logic [BLOCK-1:0]  blk_a    [STAGES];
  logic [BLOCK-1:0]  blk_b    [STAGES];
  logic [BLOCK-1:0]  blk_sum  [STAGES];
  logic [STAGES-1:0] blk_cout;
  logic [STAGES-1:0] blk_cmsb;

  // Bubble-collapsing advance chain: a stage moves when it is empty or its
  // successor moves; the last stage moves when the output is free or taken.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = !valid_q[i] || adv[i+1];
    end
  end

  // Stage 0 works straight off the input beat; SUB is folded into A + ~B + 1
  // here so later stages only ever add.
  always_comb begin
    src_valid[0] = in_valid;
    src_word[0]  = in_a;
    src_b[0]     = (in_op == OP_SUB) ? ~in_b : in_b;
    src_carry[0] = (in_op == OP_SUB) ? 1'b1 : in_cin;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_word[i]  = word_q[i-1];
      src_b[i]     = b_q[i-1];
      src_carry[i] = carry_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      blk_a[i] = src_word[i][i*BLOCK +: BLOCK];
      blk_b[i] = src_b[i][i*BLOCK +: BLOCK];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    csa_block #(
      .BLOCK(BLOCK)
    ) u_block (
      .a   (blk_a[g]),
      .b   (blk_b[g]),
      .cin (src_carry[g]),
      .sum (blk_sum[g]),
      .cout(blk_cout[g]),
      .cmsb(blk_cmsb[g])
    );
  end

  // Data only loads alongside a real beat, so bubbles never disturb the
  // values a stalled or idle output is showing.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < STAGES; i++) begin
      word_d[i] = word_q[i];
      b_d[i]    = b_q[i];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) begin
          word_d[i]                     = src_word[i];
          word_d[i][i*BLOCK +: BLOCK]   = blk_sum[i];
          b_d[i]                        = src_b[i];
          carry_d[i]                    = blk_cout[i];
        end
      end
    end
    if (adv[STAGES-1] && src_valid[STAGES-1]) begin
      ovf_d = blk_cmsb[STAGES-1] ^ blk_cout[STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        word_q[i] <= '0;
        b_q[i]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < STAGES; i++) begin
        word_q[i] <= word_d[i];
        b_q[i]    <= b_d[i];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = word_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
// Three adders side by side: (32,8), (16,16) and (24,4). Accepted beats push
// a reference result into a per-adder queue; a monitor pops and compares
// whenever an adder hands over a result.
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;
  import csa_pkg::*;

  typedef struct packed {
    logic        ovf;
    logic        carry;
    logic [31:0] sum;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iv   [3];
  logic [31:0] ia   [3];
  logic [31:0] ib   [3];
  logic        icin [3];
  op_e         iop  [3];
  logic        ordy [3];

  logic        ir [3];
  logic        ov [3];
  logic        oc [3];
  logic        of [3];
  logic [31:0] os [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, oc0, oc1, oc2, of0, of1, of2;
  logic [31:0] os0;
  logic [15:0] os1;
  logic [23:0] os2;

  exp_t sbq [3][$];
  int   total;
  int   bad;
  logic streamsDone;

  csa_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_a(ia[0]), .in_b(ib[0]),
    .in_cin(icin[0]), .in_op(iop[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .out_sum(os0), .out_carry(oc0), .out_ovf(of0));

  csa_pipe_adder #(.WIDTH(16), .BLOCK(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_a(ia[1][15:0]), .in_b(ib[1][15:0]),
    .in_cin(icin[1]), .in_op(iop[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .out_sum(os1), .out_carry(oc1), .out_ovf(of1));

  csa_pipe_adder #(.WIDTH(24), .BLOCK(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_a(ia[2][23:0]), .in_b(ib[2][23:0]),
    .in_cin(icin[2]), .in_op(iop[2]), .out_valid(ov2), .out_ready(ordy[2]),
    .out_sum(os2), .out_carry(oc2), .out_ovf(of2));

  // Gather the three adders' outputs into indexable arrays.
  always_comb begin
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    oc[0] = oc0; oc[1] = oc1; oc[2] = oc2;
    of[0] = of0; of[1] = of1; of[2] = of2;
    os[0] = os0;
    os[1] = {16'b0, os1};
    os[2] = {8'b0, os2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfgWidth(input int k);
    case (k)
      0:       return 32;
      1:       return 16;
      default: return 24;
    endcase
  endfunction

  // Reference: plain unsigned/signed arithmetic on the masked operands.
  function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input op_e op);
    exp_t            e;
    longint unsigned mask, ua, ub, ures;
    longint          sa, sb, sres, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    smax = longint'(64'd1 << (w - 1)) - 1;
    smin = -longint'(64'd1 << (w - 1));
    sa   = (ua > longint'(smax)) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = (ub > longint'(smax)) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    if (op == OP_ADD) begin
      ures    = ua + ub + {63'b0, cin};
      e.sum   = 32'(ures & mask);
      e.carry = ((ures >> w) & 64'd1) != 0;
      sres    = sa + sb + longint'(cin);
    end else begin
      e.sum   = 32'((ua - ub) & mask);
      e.carry = (ua >= ub);
      sres    = sa - sb;
    end
    e.ovf = (sres > smax) || (sres < smin);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic noteTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout required completion", name);
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input op_e op);
    int waitCycles;
    waitCycles = 0;
    ia[k] = a; ib[k] = b; icin[k] = cin; iop[k] = op; iv[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (ir[k]) begin
        @(posedge clk); #1;
        break;
      end
      waitCycles++;
      if (waitCycles > 500) begin
        noteTimeout($sformatf("accept_dut%0d", k));
        break;
      end
      @(posedge clk); #1;
    end
    iv[k] = 1'b0;
  endtask

  task automatic waitDrain(input int k);
    int waitCycles;
    waitCycles = 0;
    while (sbq[k].size() != 0 && waitCycles < 500) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput($sformatf("drain_dut%0d", k), 34'(sbq[k].size()), 34'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 >> $urandom_range(0, 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic randomStream(input int k);
    logic [31:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      a = pickOperand();
      b = pickOperand();
      applyStimulus(k, a, b, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD);
    end
  endtask

  // Accepted beats become expected results; reset discards everything in flight.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        sbq[k].delete();
      end else if (iv[k] && ir[k]) begin
        sbq[k].push_back(refModel(cfgWidth(k), ia[k], ib[k], icin[k], iop[k]));
      end
    end
  end

  // Every handed-over result is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst && ov[k] && ordy[k]) begin
        if (sbq[k].size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_dut%0d: got sum %h required no result", k, os[k]);
        end else begin
          e = sbq[k].pop_front();
          checkOutput($sformatf("result_dut%0d", k), {of[k], oc[k], os[k]}, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    int          waitCycles;
    total = 0;
    bad = 0;
    streamsDone = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; icin[k] = 1'b0; iop[k] = OP_ADD; ordy[k] = 1'b1;
    end
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_outputs_dut%0d", k), {of[k], oc[k], os[k], ov[k]}, 34'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("ready_after_reset_dut%0d", k), 34'(ir[k]), 34'd1);
    end

    $display("[TB] directed vectors");
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_cycle%0d", j), 34'(ov[0]), 34'(j == 4));
    end
    @(posedge clk); #1;
    applyStimulus(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    applyStimulus(0, 32'h0000_0010, 32'h0000_0020, 1'b1, OP_ADD);
    applyStimulus(0, 32'h0000_0005, 32'h0000_0007, 1'b1, OP_SUB);
    applyStimulus(0, 32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB);
    waitDrain(0);
    @(posedge clk); #1;

    $display("[TB] output stall");
    ordy[0] = 1'b0;
    fork
      begin
        for (int n = 0; n < 8; n++) applyStimulus(0, $urandom, $urandom, 1'b1, OP_ADD);
      end
      begin
        waitCycles = 0;
        do begin
          @(negedge clk);
          waitCycles++;
        end while (!ov[0] && waitCycles < 50);
        if (!ov[0]) noteTimeout("stall_first_valid");
        held = os[0];
        for (int j = 0; j < 6; j++) begin
          if (j > 0) @(negedge clk);
          checkOutput("stall_hold_sum", 34'(os[0]), 34'(held));
          checkOutput("stall_in_ready", 34'(ir[0]), 34'd0);
        end
        @(posedge clk); #1 ordy[0] = 1'b1;
      end
    join
    waitDrain(0);
    @(posedge clk); #1;

    $display("[TB] reset with beats in flight");
    applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD);
    applyStimulus(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, OP_SUB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_reset_valid", 34'(ov[0]), 34'd1);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_valid", 34'(ov[0]), 34'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 34'(ov[0]), 34'd0);
    end
    @(posedge clk); #1;
    applyStimulus(0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, OP_ADD);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset_latency%0d", j), 34'(ov[0]), 34'(j == 4));
    end
    waitDrain(0);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    fork
      begin
        fork
          randomStream(0);
          randomStream(1);
          randomStream(2);
        join
        streamsDone = 1'b1;
      end
      begin
        while (!streamsDone) begin
          @(posedge clk); #1;
          for (int k = 0; k < 3; k++) ordy[k] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    for (int k = 0; k < 3; k++) waitDrain(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
